// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: walks WIDTH-bit operands LSB first, BITS_PER_CYCLE bits
// per clock, through a registered carry/borrow chain, with a start/busy/done handshake.
module serial_add_sub #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  localparam int B  = BITS_PER_CYCLE;
  localparam int N  = WIDTH / B;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if ((B < 1) || (WIDTH < 2) || ((WIDTH % B) != 0)) begin : g_bad_params
    $error("serial_add_sub: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake: start is taken on any edge where the block is not busy (IDLE or DONE);
  // done is a one-cycle pulse with result/cout/zero/overflow valid, and those outputs
  // hold until the next operation completes.
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_sh_q;
  logic             mode_q, chain_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, cout_q, zero_q, ovf_q;
  logic [WIDTH-1:0] result_q;

  logic [B:0]         c_d;
  logic [B-1:0]       slice_d;
  logic [WIDTH+B-1:0] cat_d;
  logic [WIDTH-1:0]   res_d;
  logic               ovf_d;

  always_comb begin
    c_d     = '0;
    slice_d = '0;
    c_d[0]  = chain_q;
    for (int i = 0; i < B; i++) begin
      slice_d[i] = a_q[i] ^ b_q[i] ^ c_d[i];
      if (mode_q) begin
        c_d[i+1] = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & c_d[i]);
      end else begin
        c_d[i+1] = (a_q[i] & b_q[i]) | (c_d[i] & (a_q[i] ^ b_q[i]));
      end
    end
    // New slice enters at the MSB end, so after N slices the result is in place.
    cat_d = {slice_d, res_sh_q};
    res_d = cat_d[WIDTH+B-1:B];
    // Only meaningful on the final slice, where bit B-1 of the shifted operands is the MSB.
    if (mode_q) begin
      ovf_d = (a_q[B-1] != b_q[B-1]) && (slice_d[B-1] != a_q[B-1]);
    end else begin
      ovf_d = (c_d[B-1] != c_d[B]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_sh_q <= '0;
      mode_q   <= 1'b0;
      chain_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            mode_q   <= mode;
            chain_q  <= cin;
            cnt_q    <= '0;
            res_sh_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          a_q      <= a_q >> B;
          b_q      <= b_q >> B;
          res_sh_q <= res_d;
          chain_q  <= c_d[B];
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= res_d;
            cout_q   <= c_d[B];
            zero_q   <= (res_d == '0);
            ovf_q    <= ovf_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: four parameterisations share one stimulus stream and are
// checked against an arithmetic reference model.
module tb_serial_add_sub;

  logic        clk = 1'b0;
  logic        rst_n, start, mode, cin;
  logic [15:0] a_in, b_in;

  logic [3:0]  busy_v, done_v, cout_v, zero_v, ovf_v;
  logic [7:0]  r0, r1;
  logic [15:0] r2;
  logic [3:0]  r3;
  logic [1:0]  st0, st1, st2, st3;

  int checks = 0;
  int errors = 0;

  logic [18:0] exp_q[4][$];
  logic [15:0] prev_res[4];

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(8), .BITS_PER_CYCLE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a_in[7:0]), .b(b_in[7:0]),
    .cin(cin), .busy(busy_v[0]), .done(done_v[0]), .result(r0), .cout(cout_v[0]),
    .zero(zero_v[0]), .overflow(ovf_v[0]), .dbg_state(st0));
  serial_add_sub #(.WIDTH(8), .BITS_PER_CYCLE(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a_in[7:0]), .b(b_in[7:0]),
    .cin(cin), .busy(busy_v[1]), .done(done_v[1]), .result(r1), .cout(cout_v[1]),
    .zero(zero_v[1]), .overflow(ovf_v[1]), .dbg_state(st1));
  serial_add_sub #(.WIDTH(16), .BITS_PER_CYCLE(8)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a_in), .b(b_in),
    .cin(cin), .busy(busy_v[2]), .done(done_v[2]), .result(r2), .cout(cout_v[2]),
    .zero(zero_v[2]), .overflow(ovf_v[2]), .dbg_state(st2));
  serial_add_sub #(.WIDTH(4), .BITS_PER_CYCLE(2)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a_in[3:0]), .b(b_in[3:0]),
    .cin(cin), .busy(busy_v[3]), .done(done_v[3]), .result(r3), .cout(cout_v[3]),
    .zero(zero_v[3]), .overflow(ovf_v[3]), .dbg_state(st3));

  function automatic int w_of(input int i);
    case (i)
      0, 1:    return 8;
      2:       return 16;
      default: return 4;
    endcase
  endfunction

  function automatic int n_of(input int i);
    return (i == 0) ? 8 : 2;
  endfunction

  function automatic logic [15:0] res_of(input int i);
    case (i)
      0:       return {8'h00, r0};
      1:       return {8'h00, r1};
      2:       return r2;
      default: return {12'h000, r3};
    endcase
  endfunction

  function automatic logic [1:0] st_of(input int i);
    case (i)
      0:       return st0;
      1:       return st1;
      2:       return st2;
      default: return st3;
    endcase
  endfunction

  // Reference: plain integer arithmetic on w-bit operands.
  function automatic logic [18:0] model(input int w, input logic m, input logic [15:0] a,
                                        input logic [15:0] b, input logic ci);
    longint mask = (64'sd1 <<< w) - 1;
    longint half = 64'sd1 <<< (w - 1);
    longint aa = longint'(a) & mask;
    longint bb = longint'(b) & mask;
    longint ci_l = ci ? 1 : 0;
    longint s, sa, sb, ss, res;
    logic co, z, ov;
    if (!m) begin
      s   = aa + bb + ci_l;
      res = s & mask;
      co  = ((s >>> w) & 1) != 0;
      sa  = (aa >= half) ? aa - 2 * half : aa;
      sb  = (bb >= half) ? bb - 2 * half : bb;
      ss  = sa + sb + ci_l;
      ov  = (ss >= half) || (ss < -half);
    end else begin
      s   = aa - bb - ci_l;
      res = s & mask;
      co  = aa < (bb + ci_l);
      ov  = ((aa >= half) != (bb >= half)) && ((res >= half) != (aa >= half));
    end
    z = (res == 0);
    return {ov, z, co, 16'(res)};
  endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  task automatic chk_done_outputs(input int i);
    logic [18:0] e;
    if (exp_q[i].size() == 0) begin
      chk("spurious_done", i, 32'd1, 32'd0);
    end else begin
      e = exp_q[i].pop_front();
      chk("result", i, 32'(res_of(i)), 32'(e[15:0]));
      chk("cout", i, 32'(cout_v[i]), 32'(e[16]));
      chk("zero", i, 32'(zero_v[i]), 32'(e[17]));
      chk("overflow", i, 32'(ovf_v[i]), 32'(e[18]));
      prev_res[i] = e[15:0];
    end
  endtask

  task automatic run_op(input logic m, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input bit inject);
    for (int i = 0; i < 4; i++) exp_q[i].push_back(model(w_of(i), m, a, b, ci));
    @(negedge clk);
    mode = m; a_in = a; b_in = b; cin = ci; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in = 16'($urandom); b_in = 16'($urandom);
    mode = 1'($urandom);  cin = 1'($urandom);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (k == 1) chk("held_result", i, 32'(res_of(i)), 32'(prev_res[i]));
        chk("busy", i, 32'(busy_v[i]), 32'(k <= n_of(i)));
        chk("done", i, 32'(done_v[i]), 32'(k == n_of(i) + 1));
        if (done_v[i]) chk_done_outputs(i);
      end
      if (inject && k == 2) begin
        start = 1'b1; a_in = 16'($urandom); b_in = 16'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) chk("queue_empty", i, 32'(exp_q[i].size()), 32'd0);
  endtask

  task automatic run_b2b(input logic m, input logic [15:0] a, input logic [15:0] b, input logic ci);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 30 / (n_of(i) + 1); j++) exp_q[i].push_back(model(w_of(i), m, a, b, ci));
    @(negedge clk);
    mode = m; a_in = a; b_in = b; cin = ci; start = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (done_v[i]) begin
          chk("b2b_phase", i, 32'(k % (n_of(i) + 1)), 32'd0);
          chk_done_outputs(i);
        end
      end
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_count", i, 32'(exp_q[i].size()), 32'd0);
      exp_q[i].delete();
      prev_res[i] = model(w_of(i), m, a, b, ci)[15:0];
    end
  endtask

  task automatic check_all_reset(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_busy"}, i, 32'(busy_v[i]), 32'd0);
      chk({tag, "_done"}, i, 32'(done_v[i]), 32'd0);
      chk({tag, "_result"}, i, 32'(res_of(i)), 32'd0);
      chk({tag, "_flags"}, i, {29'd0, cout_v[i], zero_v[i], ovf_v[i]}, 32'd0);
      chk({tag, "_state"}, i, 32'(st_of(i)), 32'd0);
    end
  endtask

  task automatic run_reset_abort();
    @(negedge clk);
    mode = 1'b0; a_in = 16'h5A5A; b_in = 16'h2323; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_reset("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) chk("abort_no_done", i, 32'(done_v[i]), 32'd0);
    end
    for (int i = 0; i < 4; i++) prev_res[i] = '0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; cin = 1'b0; a_in = '0; b_in = '0;
    for (int i = 0; i < 4; i++) prev_res[i] = '0;
    repeat (3) @(negedge clk);
    check_all_reset("reset");
    rst_n = 1'b1;

    run_op(1'b1, 16'h0005, 16'h0003, 1'b0, 1'b0);
    run_op(1'b1, 16'h0003, 16'h0005, 1'b0, 1'b0);
    run_op(1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0);
    run_op(1'b1, 16'h0080, 16'h0001, 1'b0, 1'b0);
    run_op(1'b0, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    run_op(1'b0, 16'h007F, 16'h0001, 1'b0, 1'b0);
    run_op(1'b0, 16'h003C, 16'h0045, 1'b1, 1'b0);
    run_op(1'b1, 16'h1234, 16'h0235, 1'b0, 1'b0);
    run_op(1'b0, 16'h8000, 16'h8000, 1'b0, 1'b0);

    run_op(1'b0, 16'h0011, 16'h0022, 1'b0, 1'b1);
    run_op(1'b1, 16'h4321, 16'h1234, 1'b1, 1'b1);

    run_b2b(1'b0, 16'h1357, 16'h2468, 1'b1);

    run_reset_abort();
    run_op(1'b1, 16'hABCD, 16'h1234, 1'b0, 1'b0);

    for (int ab = 0; ab < 256; ab++)
      for (int mc = 0; mc < 4; mc++)
        run_op(mc[1], 16'(ab & 15), 16'(ab >> 4), mc[0], 1'b0);

    for (int n = 0; n < 200; n++)
      run_op(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), (n % 4) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
